// File: rtl/frame_fill_writer.sv
// Rectangle-fill write engine for the 128x96 1-bit-per-plane RGB frame BRAMs.
// Takes one fill command at a time and emits one {y,x} write per granted cycle in raster order.
module frame_fill_writer #(
  parameter int H_PIX  = 128,
  parameter int V_PIX  = 96,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [6:0]        cmd_x0,
  input  logic [6:0]        cmd_y0,
  input  logic [6:0]        cmd_x1,
  input  logic [6:0]        cmd_y1,
  input  logic [2:0]        cmd_rgb,
  input  logic              wr_allow,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_rgb,
  output logic              busy,
  output logic              done,
  output logic              cmd_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [6:0]        x0_q, y0_q, x1_q, y1_q;
  logic [6:0]        x_q, y_q;
  logic [2:0]        rgb_q;
  logic [ADDR_W-1:0] addr_hold;
  logic [ADDR_W-1:0] addr_cur;
  logic              cmd_bad;
  logic              last_px;

  always_comb begin
    cmd_bad = (x1_q < x0_q) || (y1_q < y0_q)
           || ({1'b0, x0_q} >= 8'(H_PIX)) || ({1'b0, x1_q} >= 8'(H_PIX))
           || ({1'b0, y0_q} >= 8'(V_PIX)) || ({1'b0, y1_q} >= 8'(V_PIX));
    last_px  = (x_q == x1_q) && (y_q == y1_q);
    addr_cur = ADDR_W'({y_q, x_q});
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wr_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    cmd_err   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (cmd_bad) begin
          cmd_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        busy = 1'b1;
        if (wr_allow) begin
          wr_en = 1'b1;
          if (last_px) state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address is live only while writing; otherwise it replays the last written address.
  assign wr_addr = wr_en ? addr_cur : addr_hold;
  assign wr_rgb  = wr_en ? rgb_q : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      rgb_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      addr_hold <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cmd_valid) begin
        x0_q  <= cmd_x0;
        y0_q  <= cmd_y0;
        x1_q  <= cmd_x1;
        y1_q  <= cmd_y1;
        rgb_q <= cmd_rgb;
      end
      if (state == CHECK) begin
        x_q <= x0_q;
        y_q <= y0_q;
      end
      if (wr_en) begin
        addr_hold <= addr_cur;
        // y stays on y1 after the final pixel so the counters never run past the rectangle
        if (x_q == x1_q) begin
          x_q <= x0_q;
          if (!last_px) y_q <= y_q + 7'd1;
        end else begin
          x_q <= x_q + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_fill_writer.sv
// Directed self-checking bench for frame_fill_writer: fills, stalls, rejects, overlap and mid-fill reset.
module tb_frame_fill_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [2:0]  cmd_rgb;
  logic        wr_allow;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [2:0]  wr_rgb;
  logic        busy, done, cmd_err;

  int unsigned checks = 0;
  int unsigned fails  = 0;
  logic [13:0] last_addr = '0;

  frame_fill_writer #(.H_PIX(128), .V_PIX(96), .ADDR_W(14)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_rgb(cmd_rgb),
    .wr_allow(wr_allow), .wr_en(wr_en), .wr_addr(wr_addr), .wr_rgb(wr_rgb),
    .busy(busy), .done(done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; wr_allow = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_rgb = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({cmd_ready, wr_en, busy, done, cmd_err} !== 5'b10000 || wr_addr !== 14'h0 || wr_rgb !== 3'b000) begin
      fails++;
      $display("FAIL reset_state: ready/wr_en/busy/done/err=%b addr=%h rgb=%b, required 10000 0000 000",
               {cmd_ready, wr_en, busy, done, cmd_err}, wr_addr, wr_rgb);
    end
    @(negedge clk);
    reset = 1'b1;
    last_addr = '0;
  endtask

  task automatic send_cmd(input string name, input logic [6:0] x0, y0, x1, y1, input logic [2:0] rgb);
    @(negedge clk);
    cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_rgb = rgb;
    cmd_valid = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_ready_idle: cmd_ready=%b required 1", name, cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Accepts a command and follows the fill against a raster model until done.
  task automatic run_fill(input string name, input logic [6:0] x0, y0, x1, y1, input logic [2:0] rgb,
                          input bit toggle, input bit intrude, input int budget);
    logic [6:0] ex, ey;
    int nw, nd, first_cyc, exp_n, cyc;
    ex = x0; ey = y0; nw = 0; nd = 0; first_cyc = -1;
    exp_n = (int'(x1) - int'(x0) + 1) * (int'(y1) - int'(y0) + 1);
    send_cmd(name, x0, y0, x1, y1, rgb);
    for (cyc = 0; cyc < budget && nd == 0; cyc++) begin
      @(negedge clk);
      wr_allow = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (intrude && cyc < 4) begin
        cmd_valid = 1'b1; cmd_x0 = 7'd0; cmd_y0 = 7'd0; cmd_x1 = 7'd1; cmd_y1 = 7'd1; cmd_rgb = 3'b111;
      end else begin
        cmd_valid = 1'b0;
      end
      #1;
      if (intrude && cyc < 4) begin
        checks++;
        if (cmd_ready !== 1'b0) begin
          fails++;
          $display("FAIL %s_ready_busy: cmd_ready=%b required 0 (cycle %0d)", name, cmd_ready, cyc);
        end
      end
      if (wr_en === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        checks++;
        if (wr_allow !== 1'b1 || wr_addr !== {ey, ex} || wr_rgb !== rgb || nw >= exp_n) begin
          fails++;
          if (fails < 20)
            $display("FAIL %s_write: write %0d addr=%h rgb=%b allow=%b, required addr=%h rgb=%b allow=1 max %0d writes",
                     name, nw, wr_addr, wr_rgb, wr_allow, {ey, ex}, rgb, exp_n);
        end
        last_addr = {ey, ex};
        nw++;
        if (ex == x1) begin ex = x0; ey = ey + 7'd1; end
        else ex = ex + 7'd1;
      end else begin
        checks++;
        if (wr_addr !== last_addr) begin
          fails++;
          if (fails < 20)
            $display("FAIL %s_addr_hold: addr=%h required %h while idle", name, wr_addr, last_addr);
        end
      end
      if (done === 1'b1) nd++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (nd != 1 || nw != exp_n) begin
      fails++;
      $display("FAIL %s_count: writes=%0d done=%0d, required writes=%0d done=1", name, nw, nd, exp_n);
    end
    if (!toggle) begin
      checks++;
      if (first_cyc != 1) begin
        fails++;
        $display("FAIL %s_latency: first write in cycle %0d after accept, required 1", name, first_cyc);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, done, cmd_ready, wr_en} !== 4'b0010) begin
      fails++;
      $display("FAIL %s_after_done: busy/done/ready/wr_en=%b required 0010", name, {busy, done, cmd_ready, wr_en});
    end
  endtask

  task automatic test_reject(input string name, input logic [6:0] x0, y0, x1, y1);
    send_cmd(name, x0, y0, x1, y1, 3'b111);
    @(negedge clk);
    wr_allow = 1'b1;
    #1;
    checks++;
    if ({cmd_err, wr_en, busy, cmd_ready} !== 4'b1010) begin
      fails++;
      $display("FAIL %s_check: err/wr_en/busy/ready=%b required 1010", name, {cmd_err, wr_en, busy, cmd_ready});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({cmd_err, wr_en, busy, cmd_ready, done} !== 5'b00010 || wr_addr !== last_addr) begin
      fails++;
      $display("FAIL %s_return: err/wr_en/busy/ready/done=%b addr=%h required 00010 addr=%h",
               name, {cmd_err, wr_en, busy, cmd_ready, done}, wr_addr, last_addr);
    end
  endtask

  task automatic test_reset_mid_fill();
    int nw;
    nw = 0;
    send_cmd("midrst", 7'd0, 7'd0, 7'd127, 7'd95, 3'b110);
    for (int cyc = 0; cyc < 200 && nw < 100; cyc++) begin
      @(negedge clk);
      wr_allow = 1'b1;
      #1;
      if (wr_en === 1'b1) nw++;
    end
    checks++;
    if (nw != 100) begin
      fails++;
      $display("FAIL midrst_progress: writes=%0d required 100", nw);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, wr_en, busy, done, cmd_err} !== 5'b10000 || wr_addr !== 14'h0 || wr_rgb !== 3'b000) begin
      fails++;
      $display("FAIL midrst_async: ready/wr_en/busy/done/err=%b addr=%h rgb=%b, required 10000 0000 000",
               {cmd_ready, wr_en, busy, done, cmd_err}, wr_addr, wr_rgb);
    end
    repeat (2) begin
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || wr_en !== 1'b0) begin
        fails++;
        $display("FAIL midrst_no_done: done=%b wr_en=%b required 0 0", done, wr_en);
      end
    end
    reset = 1'b1;
    last_addr = '0;
    run_fill("midrst_after", 7'd10, 7'd20, 7'd12, 7'd21, 3'b010, 1'b0, 1'b0, 40);
  endtask

  initial begin
    test_reset();
    run_fill("full", 7'd0, 7'd0, 7'd127, 7'd95, 3'b101, 1'b0, 1'b0, 12400);
    checks++;
    if (last_addr !== 14'h2FFF || wr_addr !== 14'h2FFF) begin
      fails++;
      $display("FAIL full_last_addr: wr_addr=%h required 2fff", wr_addr);
    end
    run_fill("small", 7'd10, 7'd20, 7'd12, 7'd21, 3'b010, 1'b0, 1'b0, 40);
    run_fill("single_stall", 7'd5, 7'd5, 7'd5, 7'd5, 3'b011, 1'b1, 1'b0, 40);
    checks++;
    if (wr_addr !== 14'h0285) begin
      fails++;
      $display("FAIL single_hold: wr_addr=%h required 0285", wr_addr);
    end
    test_reject("rej_x", 7'd4, 7'd0, 7'd3, 7'd0);
    test_reject("rej_y", 7'd0, 7'd0, 7'd0, 7'd96);
    run_fill("overlap", 7'd10, 7'd20, 7'd12, 7'd21, 3'b010, 1'b0, 1'b1, 40);
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
